alu_rr_sched: RTL

// - Two-requester round-robin scheduler sharing one combinational 8-bit ALU (A, B, 4-bit instruction -> F).
// - Each requester opens a job (start + beat count), then streams operand beats over valid/ready.
// - Muxes the granted beat onto the ALU and registers F with requester ID; pulses per-requester done at job end.
// - Sits between the operand sources and the ALU instance in the top level.

---
 rtl/alu_rr_sched_if.sv | 40 ++++
 rtl/alu_rr_sched.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_rr_sched_if.sv
// Bundles the requester, ALU and result signals of alu_rr_sched.
// master: operand sources / ALU / result consumer side.
// slave:  the scheduler itself.
//   start0/1, count0/1     job open request and beat count
//   valid0/1, a*, b*, instr* operand beats; ready0/1 accept; done0/1 job end
//   alu_A/alu_B/alu_instr  to ALU; alu_F combinational result back
//   res_valid/data/id      registered result; gnt_cnt0/1 accepted-beat counters
interface alu_rr_sched_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
);
    logic          start0, start1;
    logic [CW-1:0] count0, count1;
    logic          valid0, valid1;
    logic [DW-1:0] a0, a1, b0, b1;
    logic [3:0]    instr0, instr1;
    logic          ready0, ready1;
    logic          done0, done1;
    logic [DW-1:0] alu_A, alu_B;
    logic [3:0]    alu_instr;
    logic [DW-1:0] alu_F;
    logic          res_valid;
    logic [DW-1:0] res_data;
    logic          res_id;
    logic [15:0]   gnt_cnt0, gnt_cnt1;

    modport master (
        output start0, start1, count0, count1, valid0, valid1,
               a0, a1, b0, b1, instr0, instr1, alu_F,
        input  ready0, ready1, done0, done1, alu_A, alu_B, alu_instr,
               res_valid, res_data, res_id, gnt_cnt0, gnt_cnt1
    );

    modport slave (
        input  start0, start1, count0, count1, valid0, valid1,
               a0, a1, b0, b1, instr0, instr1, alu_F,
        output ready0, ready1, done0, done1, alu_A, alu_B, alu_instr,
               res_valid, res_data, res_id, gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/alu_rr_sched.sv
// Two-requester round-robin scheduler in front of one combinational ALU.
// Each requester opens a job (start + count) and streams operand beats; the
// granted beat is muxed onto the ALU and its result registered with the
// requester ID one cycle later. done pulses alongside the last result.
// Ports: clk, rst_n (async active-low), bus (alu_rr_sched_if.slave).
// Optional feature macro: ALU_GNT_CNT_EN enables the per-requester
// accepted-beat counters gnt_cnt0/1; otherwise they read 0.
module alu_rr_sched #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_rr_sched_if.slave  bus
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t        st_q [2];
    state_t        st_d [2];
    logic [CW-1:0] rem_q [2];
    logic [CW-1:0] rem_d [2];
    logic [1:0]    done_q, done_d;
    logic          last_q, last_d;
    logic          res_valid_q, res_valid_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          res_id_q, res_id_d;

    logic [1:0]    start, valid, elig, gnt;
    logic [CW-1:0] count [2];

    assign start    = {bus.start1, bus.start0};
    assign valid    = {bus.valid1, bus.valid0};
    assign count[0] = bus.count0;
    assign count[1] = bus.count1;

    // Round-robin grant: on contention the requester not granted last wins.
    always_comb begin
        elig[0] = (st_q[0] == ACTIVE) & valid[0];
        elig[1] = (st_q[1] == ACTIVE) & valid[1];
        gnt     = elig;
        if (elig == 2'b11) begin
            gnt = last_q ? 2'b01 : 2'b10;
        end
    end

    assign bus.ready0    = gnt[0];
    assign bus.ready1    = gnt[1];
    assign bus.alu_A     = gnt[0] ? bus.a0 : (gnt[1] ? bus.a1 : DW'(0));
    assign bus.alu_B     = gnt[0] ? bus.b0 : (gnt[1] ? bus.b1 : DW'(0));
    assign bus.alu_instr = gnt[0] ? bus.instr0 : (gnt[1] ? bus.instr1 : 4'd0);

    // Next state for both job FSMs and the result register.
    always_comb begin
        done_d      = 2'b00;
        last_d      = last_q;
        res_valid_d = |gnt;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        for (int i = 0; i < 2; i++) begin
            st_d[i]  = st_q[i];
            rem_d[i] = rem_q[i];
            case (st_q[i])
                IDLE: begin
                    if (start[i]) begin
                        if (count[i] != CW'(0)) begin
                            st_d[i]  = ACTIVE;
                            rem_d[i] = count[i];
                        end else begin
                            done_d[i] = 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (gnt[i]) begin
                        rem_d[i] = rem_q[i] - CW'(1);
                        if (rem_q[i] == CW'(1)) begin
                            st_d[i]   = IDLE;
                            done_d[i] = 1'b1;
                        end
                    end
                end
            endcase
        end
        if (|gnt) begin
            res_data_d = bus.alu_F;
            res_id_d   = gnt[1];
            last_d     = gnt[1];
        end
    end

    // State register; reset leaves last_gnt at 1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= IDLE;
                rem_q[i] <= CW'(0);
            end
            done_q      <= 2'b00;
            last_q      <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= DW'(0);
            res_id_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                st_q[i]  <= st_d[i];
                rem_q[i] <= rem_d[i];
            end
            done_q      <= done_d;
            last_q      <= last_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

    assign bus.done0     = done_q[0];
    assign bus.done1     = done_q[1];
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_id    = res_id_q;

`ifdef ALU_GNT_CNT_EN
    logic [15:0] cnt_q [2];

    // Accepted-beat counters, free-running with natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q[0] <= 16'd0;
            cnt_q[1] <= 16'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign bus.gnt_cnt0 = cnt_q[0];
    assign bus.gnt_cnt1 = cnt_q[1];
`else
    assign bus.gnt_cnt0 = 16'd0;
    assign bus.gnt_cnt1 = 16'd0;
`endif
endmodule
